hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 34 +++
 rtl/hazard_ctrl_sat_counter.sv | 21 ++
 rtl/hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: RV32I opcode encodings,
// the held-response FSM state and the source-register usage helpers.
package hazardctrl;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  // WAIT_I: D-cache data is parked in dbuf, still waiting on the I-cache.
  // WAIT_D: I-cache data is parked in ibuf, still waiting on the D-cache.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_WAIT_I = 2'd1,
    ST_WAIT_D = 2'd2
  } hc_state_e;

  function automatic logic uses_rs1(input rv32i_opcode op);
    return op inside {op_reg, op_imm, op_load, op_store, op_br, op_jalr};
  endfunction

  function automatic logic uses_rs2(input rv32i_opcode op);
    return op inside {op_reg, op_store, op_br};
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes and cache-miss
// stalls, with buffering of a response that arrives while the other side stalls.
module hazard_ctrl
  import hazardctrl::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       fd_rs1,
  input  logic [4:0]       fd_rs2,
  input  rv32i_opcode      fd_opcode,
  input  logic             fd_valid,
  input  logic [4:0]       de_rd,
  input  rv32i_opcode      de_opcode,
  input  logic             de_valid,
  input  logic             br_taken,
  input  logic             imem_read,
  input  logic             imem_resp,
  input  logic [31:0]      imem_rdata,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic [31:0]      dmem_rdata,
  output logic             imem_read_out,
  output logic             dmem_req_out,
  output logic [31:0]      instr_out,
  output logic [31:0]      dmem_rdata_out,
  output logic             pc_load,
  output logic             fd_load,
  output logic             de_load,
  output logic             em_load,
  output logic             mw_load,
  output logic             fd_flush,
  output logic             de_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output hc_state_e        dbg_state
);

  hc_state_e   r_state;
  logic [31:0] r_ibuf;
  logic [31:0] r_dbuf;

  logic w_i_held;
  logic w_d_held;
  logic w_i_pend;
  logic w_d_pend;
  logic w_mem_stall;
  logic w_load_use;
  logic w_hit_rs1;
  logic w_hit_rs2;
  logic w_stall_inc;
  logic w_bubble_inc;
  logic w_flush_inc;

  // Both flags can never be set together: a second response ends the stall.
  assign w_i_held = (r_state == ST_WAIT_D);
  assign w_d_held = (r_state == ST_WAIT_I);

  assign w_i_pend    = imem_read & ~w_i_held & ~imem_resp;
  assign w_d_pend    = dmem_req  & ~w_d_held & ~dmem_resp;
  assign w_mem_stall = w_i_pend | w_d_pend;

  assign w_hit_rs1  = uses_rs1(fd_opcode) && (fd_rs1 == de_rd);
  assign w_hit_rs2  = uses_rs2(fd_opcode) && (fd_rs2 == de_rd);
  assign w_load_use = de_valid && (de_opcode == op_load) && (de_rd != 5'd0) &&
                      fd_valid && (w_hit_rs1 || w_hit_rs2);

  assign imem_read_out  = imem_read & ~w_i_held;
  assign dmem_req_out   = dmem_req  & ~w_d_held;
  assign instr_out      = w_i_held ? r_ibuf : imem_rdata;
  assign dmem_rdata_out = w_d_held ? r_dbuf : dmem_rdata;
  assign dbg_state      = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_ibuf  <= '0;
      r_dbuf  <= '0;
    end else begin
      if (w_mem_stall && imem_resp) r_ibuf <= imem_rdata;
      if (w_mem_stall && dmem_resp) r_dbuf <= dmem_rdata;
      case (r_state)
        ST_RUN: begin
          if (!w_mem_stall)   r_state <= ST_RUN;
          else if (imem_resp) r_state <= ST_WAIT_D;
          else if (dmem_resp) r_state <= ST_WAIT_I;
        end
        ST_WAIT_I: if (!w_mem_stall) r_state <= ST_RUN;
        ST_WAIT_D: if (!w_mem_stall) r_state <= ST_RUN;
        default:   r_state <= ST_RUN;
      endcase
    end
  end

  // Latch control, in priority order: reset, memory stall, branch, load-use.
  always_comb begin
    pc_load   = 1'b1;
    fd_load   = 1'b1;
    de_load   = 1'b1;
    em_load   = 1'b1;
    mw_load   = 1'b1;
    fd_flush  = 1'b0;
    de_bubble = 1'b0;
    if (rst) begin
      {pc_load, fd_load, de_load, em_load, mw_load} = 5'b00000;
      fd_flush  = 1'b1;
      de_bubble = 1'b1;
    end else if (w_mem_stall) begin
      {pc_load, fd_load, de_load, em_load, mw_load} = 5'b00000;
    end else if (br_taken) begin
      fd_flush  = 1'b1;
      de_bubble = 1'b1;
    end else if (w_load_use) begin
      pc_load   = 1'b0;
      fd_load   = 1'b0;
      de_bubble = 1'b1;
    end
  end

  assign w_stall_inc  = w_mem_stall;
  assign w_flush_inc  = ~w_mem_stall & br_taken;
  assign w_bubble_inc = ~w_mem_stall & ~br_taken & w_load_use;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_bubble_inc),
    .count (bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scenarios plus a randomized run, all checked against a rule-level
// model of the hazard controller; a 4-bit-counter instance covers saturation.
module tb_hazard_ctrl;
  import hazardctrl::*;

  logic        clk;
  logic        rst;
  logic [4:0]  fd_rs1, fd_rs2, de_rd;
  rv32i_opcode fd_opcode, de_opcode;
  logic        fd_valid, de_valid, br_taken;
  logic        imem_read, imem_resp, dmem_req, dmem_resp;
  logic [31:0] imem_rdata, dmem_rdata;

  logic        imem_read_out, dmem_req_out;
  logic [31:0] instr_out, dmem_rdata_out;
  logic        pc_load, fd_load, de_load, em_load, mw_load, fd_flush, de_bubble;
  logic [31:0] stall_cnt, bubble_cnt, flush_cnt;
  hc_state_e   dbg_state;

  logic        imem_read_out4, dmem_req_out4;
  logic [31:0] instr_out4, dmem_rdata_out4;
  logic        pc_load4, fd_load4, de_load4, em_load4, mw_load4, fd_flush4, de_bubble4;
  logic [3:0]  stall_cnt4, bubble_cnt4, flush_cnt4;
  hc_state_e   dbg_state4;

  int n_cmp;
  int n_fail;

  // reference model state
  logic        m_i_held, m_d_held;
  logic [31:0] m_ibuf, m_dbuf;
  int          m_s, m_b, m_f;

  rv32i_opcode op_tab [10] = '{op_lui, op_auipc, op_jal, op_jalr, op_br,
                               op_load, op_store, op_imm, op_reg, op_csr};

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .fd_rs1(fd_rs1), .fd_rs2(fd_rs2), .fd_opcode(fd_opcode),
    .fd_valid(fd_valid), .de_rd(de_rd), .de_opcode(de_opcode), .de_valid(de_valid),
    .br_taken(br_taken), .imem_read(imem_read), .imem_resp(imem_resp),
    .imem_rdata(imem_rdata), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .dmem_rdata(dmem_rdata), .imem_read_out(imem_read_out), .dmem_req_out(dmem_req_out),
    .instr_out(instr_out), .dmem_rdata_out(dmem_rdata_out), .pc_load(pc_load),
    .fd_load(fd_load), .de_load(de_load), .em_load(em_load), .mw_load(mw_load),
    .fd_flush(fd_flush), .de_bubble(de_bubble), .stall_cnt(stall_cnt),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt), .dbg_state(dbg_state)
  );

  hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .fd_rs1(fd_rs1), .fd_rs2(fd_rs2), .fd_opcode(fd_opcode),
    .fd_valid(fd_valid), .de_rd(de_rd), .de_opcode(de_opcode), .de_valid(de_valid),
    .br_taken(br_taken), .imem_read(imem_read), .imem_resp(imem_resp),
    .imem_rdata(imem_rdata), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .dmem_rdata(dmem_rdata), .imem_read_out(imem_read_out4), .dmem_req_out(dmem_req_out4),
    .instr_out(instr_out4), .dmem_rdata_out(dmem_rdata_out4), .pc_load(pc_load4),
    .fd_load(fd_load4), .de_load(de_load4), .em_load(em_load4), .mw_load(mw_load4),
    .fd_flush(fd_flush4), .de_bubble(de_bubble4), .stall_cnt(stall_cnt4),
    .bubble_cnt(bubble_cnt4), .flush_cnt(flush_cnt4), .dbg_state(dbg_state4)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int sat4(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  function automatic logic reads_rs1(input rv32i_opcode op);
    case (op)
      op_reg, op_imm, op_load, op_store, op_br, op_jalr: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic reads_rs2(input rv32i_opcode op);
    case (op)
      op_reg, op_store, op_br: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_i_held = 1'b0;
    m_d_held = 1'b0;
    m_ibuf   = '0;
    m_dbuf   = '0;
    m_s = 0;
    m_b = 0;
    m_f = 0;
  endtask

  task automatic set_idle();
    fd_rs1 = '0; fd_rs2 = '0; de_rd = '0;
    fd_opcode = op_imm; de_opcode = op_imm;
    fd_valid = 1'b0; de_valid = 1'b0; br_taken = 1'b0;
    imem_read = 1'b0; imem_resp = 1'b0; dmem_req = 1'b0; dmem_resp = 1'b0;
    imem_rdata = '0; dmem_rdata = '0;
  endtask

  // Called just after a rising edge; reset asserts immediately (asynchronous).
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_enables", 32'({pc_load, fd_load, de_load, em_load, mw_load}), 32'h0);
    chk("rst_flush_bubble", 32'({fd_flush, de_bubble}), 32'h3);
    chk("rst_counters", stall_cnt | bubble_cnt | flush_cnt, 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(ST_RUN));
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock: compare every output with the model at the falling edge, then
  // advance the model to what the rising edge should produce.
  task automatic cycle();
    logic       i_pend, d_pend, stall, lu;
    logic [4:0] e_en;
    logic       e_fl, e_bb;
    hc_state_e  e_st;
    @(negedge clk);
    i_pend = imem_read && !m_i_held && !imem_resp;
    d_pend = dmem_req && !m_d_held && !dmem_resp;
    stall  = i_pend || d_pend;
    lu = de_valid && (de_opcode == op_load) && (de_rd != 0) && fd_valid &&
         ((reads_rs1(fd_opcode) && fd_rs1 == de_rd) || (reads_rs2(fd_opcode) && fd_rs2 == de_rd));
    if (stall)         begin e_en = 5'b00000; e_fl = 0; e_bb = 0; end
    else if (br_taken) begin e_en = 5'b11111; e_fl = 1; e_bb = 1; end
    else if (lu)       begin e_en = 5'b00111; e_fl = 0; e_bb = 1; end
    else               begin e_en = 5'b11111; e_fl = 0; e_bb = 0; end
    e_st = m_i_held ? ST_WAIT_D : (m_d_held ? ST_WAIT_I : ST_RUN);

    chk("enables", 32'({pc_load, fd_load, de_load, em_load, mw_load}), 32'(e_en));
    chk("flush_bubble", 32'({fd_flush, de_bubble}), 32'({e_fl, e_bb}));
    chk("mem_req_out", 32'({imem_read_out, dmem_req_out}),
        32'({imem_read && !m_i_held, dmem_req && !m_d_held}));
    chk("instr_out", instr_out, m_i_held ? m_ibuf : imem_rdata);
    chk("dmem_rdata_out", dmem_rdata_out, m_d_held ? m_dbuf : dmem_rdata);
    chk("state", 32'(dbg_state), 32'(e_st));
    chk("stall_cnt", stall_cnt, 32'(m_s));
    chk("bubble_cnt", bubble_cnt, 32'(m_b));
    chk("flush_cnt", flush_cnt, 32'(m_f));
    chk("stall_cnt4", 32'(stall_cnt4), 32'(sat4(m_s)));
    chk("bubble_cnt4", 32'(bubble_cnt4), 32'(sat4(m_b)));
    chk("flush_cnt4", 32'(flush_cnt4), 32'(sat4(m_f)));

    if (stall) begin
      m_s++;
      if (imem_resp) begin m_i_held = 1'b1; m_ibuf = imem_rdata; end
      if (dmem_resp) begin m_d_held = 1'b1; m_dbuf = dmem_rdata; end
    end else begin
      m_i_held = 1'b0;
      m_d_held = 1'b0;
      if (br_taken) m_f++;
      else if (lu)  m_b++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    set_idle();
    model_reset();
    @(posedge clk);
    #1;

    // load-use bubble, then a normal cycle
    do_reset();
    de_valid = 1; de_opcode = op_load; de_rd = 5;
    fd_valid = 1; fd_opcode = op_reg; fd_rs1 = 5; fd_rs2 = 1;
    #1;
    chk("lu_pc_load", 32'(pc_load), 32'h0);
    chk("lu_de_bubble", 32'(de_bubble), 32'h1);
    cycle();
    de_valid = 0;
    #1;
    chk("after_lu_pc_load", 32'(pc_load), 32'h1);
    chk("after_lu_de_bubble", 32'(de_bubble), 32'h0);
    chk("after_lu_bubble_cnt", bubble_cnt, 32'h1);
    cycle();

    // load to x0 never creates a hazard
    do_reset();
    set_idle();
    de_valid = 1; de_opcode = op_load; de_rd = 0;
    fd_valid = 1; fd_opcode = op_reg; fd_rs1 = 0; fd_rs2 = 0;
    #1;
    chk("x0_enables", 32'({pc_load, fd_load, de_load, em_load, mw_load}), 32'h1f);
    chk("x0_de_bubble", 32'(de_bubble), 32'h0);
    cycle();

    // I-cache answers at cycle 2, D-cache at cycle 5
    do_reset();
    set_idle();
    imem_read = 1; dmem_req = 1;
    for (int c = 0; c < 7; c++) begin
      imem_resp  = (c == 2);
      imem_rdata = (c == 2) ? 32'h00500293 : $urandom;
      dmem_resp  = (c == 5);
      dmem_rdata = $urandom;
      #1;
      if (c <= 4) chk("miss_enables", 32'({pc_load, fd_load, de_load, em_load, mw_load}), 32'h0);
      if (c >= 3 && c <= 5) chk("miss_imem_read_out", 32'(imem_read_out), 32'h0);
      if (c == 5) begin
        chk("miss_instr_out", instr_out, 32'h00500293);
        chk("miss_stall_cnt", stall_cnt, 32'd5);
        chk("miss_release", 32'(pc_load), 32'h1);
      end
      cycle();
    end

    // branch wins over a simultaneous load-use
    do_reset();
    set_idle();
    de_valid = 1; de_opcode = op_load; de_rd = 5;
    fd_valid = 1; fd_opcode = op_reg; fd_rs1 = 5; fd_rs2 = 2;
    br_taken = 1;
    #1;
    chk("br_lu_flush_bubble", 32'({fd_flush, de_bubble}), 32'h3);
    chk("br_lu_pc_load", 32'(pc_load), 32'h1);
    cycle();
    set_idle();
    #1;
    chk("br_lu_flush_cnt", flush_cnt, 32'h1);
    chk("br_lu_bubble_cnt", bubble_cnt, 32'h0);
    cycle();

    // both caches answer together: no stall, nothing captured
    do_reset();
    set_idle();
    imem_read = 1; dmem_req = 1; imem_resp = 1; dmem_resp = 1;
    imem_rdata = 32'hdeadbeef; dmem_rdata = 32'hcafef00d;
    #1;
    chk("both_resp_pc_load", 32'(pc_load), 32'h1);
    cycle();
    imem_resp = 0; dmem_resp = 0;
    imem_rdata = 32'h12345678; dmem_rdata = 32'h9abcdef0;
    #1;
    chk("both_resp_no_ibuf", instr_out, 32'h12345678);
    chk("both_resp_no_dbuf", dmem_rdata_out, 32'h9abcdef0);
    cycle();

    // reset pulse while waiting on the D-cache
    do_reset();
    set_idle();
    imem_read = 1; dmem_req = 1; imem_resp = 1; imem_rdata = 32'h0badf00d;
    cycle();
    imem_resp = 0; imem_rdata = 32'h11112222;
    #1;
    chk("wait_d_state", 32'(dbg_state), 32'(ST_WAIT_D));
    chk("wait_d_instr", instr_out, 32'h0badf00d);
    rst = 1;
    #1;
    chk("midrst_state", 32'(dbg_state), 32'(ST_RUN));
    chk("midrst_imem_read_out", 32'(imem_read_out), 32'h1);
    chk("midrst_instr_out", instr_out, 32'h11112222);
    chk("midrst_counters", stall_cnt | bubble_cnt | flush_cnt, 32'h0);
    chk("midrst_enables", 32'({pc_load, fd_load, de_load, em_load, mw_load}), 32'h0);
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    cycle();

    // long stall: the 4-bit counter sticks at 15
    do_reset();
    set_idle();
    imem_read = 1;
    for (int c = 0; c < 20; c++) cycle();
    #1;
    chk("sat_stall_cnt4", 32'(stall_cnt4), 32'd15);
    chk("sat_stall_cnt", stall_cnt, 32'd20);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 600; c++) begin
      fd_valid   = ($urandom_range(0, 3) != 0);
      de_valid   = ($urandom_range(0, 3) != 0);
      fd_opcode  = op_tab[$urandom_range(0, 9)];
      de_opcode  = ($urandom_range(0, 1) != 0) ? op_load : op_tab[$urandom_range(0, 9)];
      fd_rs1     = 5'($urandom_range(0, 3));
      fd_rs2     = 5'($urandom_range(0, 3));
      de_rd      = 5'($urandom_range(0, 3));
      br_taken   = ($urandom_range(0, 7) == 0);
      imem_read  = ($urandom_range(0, 4) != 0);
      imem_resp  = ($urandom_range(0, 2) == 0);
      dmem_req   = ($urandom_range(0, 2) == 0);
      dmem_resp  = ($urandom_range(0, 2) == 0);
      imem_rdata = $urandom;
      dmem_rdata = $urandom;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
